// File: rtl/hash_ctrl_pkg.sv
// Shared types and constants for the hash block controller.
// Holds the FSM encoding, block geometry and digest-length clamp.
package hash_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_COMP = 3'd2,
    ST_FIN  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam int          ROUNDS      = 10;
  localparam int          BLOCK_BYTES = 64;
  localparam int          MAX_NN      = 32;
  localparam logic [7:0]  PARAM_WORD  = 8'h01;
  localparam logic [5:0]  LAST_IDX    = 6'(BLOCK_BYTES - 1);

  // Out-of-range digest lengths (0 or above 32) fall back to a full 32-byte digest.
  function automatic logic [5:0] digest_len(input logic [5:0] nn);
    if (nn >= 6'd1 && nn <= 6'(MAX_NN))
      return nn;
    else
      return 6'(MAX_NN);
  endfunction

endpackage

// File: rtl/hash_round_cnt.sv
// Round/half-round sequencer for the compression phase.
// Steps (round, diag) from (0,0) to (ROUNDS-1,1) and flags the final half.
module hash_round_cnt
  import hash_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       en,
  output logic [3:0] round,
  output logic       diag,
  output logic       done
);

  assign done = (round == 4'(ROUNDS - 1)) && diag;

  always_ff @(posedge clk) begin
    if (!nreset || start) begin
      round <= 4'd0;
      diag  <= 1'b0;
    end else if (en) begin
      if (done) begin
        round <= 4'd0;
        diag  <= 1'b0;
      end else if (diag) begin
        round <= round + 4'd1;
        diag  <= 1'b0;
      end else begin
        diag  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_ctrl.sv
// Sequencer for a 64-byte-block hash core: loads message bytes, runs the
// 20 half-round compression, finalises each block and streams the digest.
module hash_ctrl
  import hash_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        data_v_i,
  input  logic [7:0]  data_i,
  input  logic [5:0]  data_idx_i,
  input  logic        block_first_i,
  input  logic        block_last_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  output logic        ready_v_o,
  output logic        msg_we_o,
  output logic [5:0]  msg_idx_o,
  output logic [7:0]  msg_o,
  output logic        h_init_o,
  output logic        cmp_start_o,
  output logic [3:0]  round_o,
  output logic        diag_o,
  output logic [63:0] t_o,
  output logic        last_o,
  output logic        fin_o,
  output logic        hash_v_o,
  output logic [5:0]  hash_idx_o,
  output logic        err_o
);

  state_t      state;
  logic [63:0] t_q;
  logic        last_q;
  logic        err_q;
  logic [5:0]  hash_idx_q;

  logic        in_accept_state;
  logic        first_byte;
  logic        block_end;
  logic        busy;
  logic        rnd_done;
  logic [63:0] key_bias;
  logic [63:0] t_next_blk;

  assign in_accept_state = (state == ST_IDLE) || (state == ST_LOAD);
  assign busy            = (state == ST_COMP) || (state == ST_FIN) || (state == ST_OUT);
  assign first_byte      = data_v_i && (data_idx_i == 6'd0) && block_first_i;
  assign block_end       = (state == ST_LOAD) && data_v_i && (data_idx_i == LAST_IDX);

  // A keyed message carries one extra (key) block in the byte count.
  assign key_bias   = (kk_i != 6'd0) ? 64'(BLOCK_BYTES) : 64'd0;
  assign t_next_blk = block_last_i ? (ll_i + key_bias) : (t_q + 64'(BLOCK_BYTES));

  hash_round_cnt u_round_cnt (
    .clk    (clk),
    .nreset (nreset),
    .start  (block_end),
    .en     (state == ST_COMP),
    .round  (round_o),
    .diag   (diag_o),
    .done   (rnd_done)
  );

  assign ready_v_o   = in_accept_state;
  assign h_init_o    = in_accept_state && first_byte;
  assign msg_we_o    = ((state == ST_IDLE) && first_byte) || ((state == ST_LOAD) && data_v_i);
  assign msg_idx_o   = data_idx_i;
  assign msg_o       = data_i;
  assign cmp_start_o = (state == ST_COMP) && (round_o == 4'd0) && !diag_o;
  assign t_o         = t_q;
  assign last_o      = last_q && ((state == ST_COMP) || (state == ST_FIN));
  assign fin_o       = (state == ST_FIN);
  assign hash_v_o    = (state == ST_OUT);
  assign hash_idx_o  = hash_idx_q;
  assign err_o       = err_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      t_q        <= 64'd0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      hash_idx_q <= 6'd0;
    end else begin
      if (data_v_i && busy)
        err_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (first_byte) begin
            t_q   <= 64'd0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (first_byte)
            t_q <= 64'd0;
          if (block_end) begin
            last_q <= block_last_i;
            t_q    <= t_next_blk;
            state  <= ST_COMP;
          end
        end
        ST_COMP: begin
          if (rnd_done)
            state <= ST_FIN;
        end
        ST_FIN: begin
          hash_idx_q <= 6'd0;
          state      <= last_q ? ST_OUT : ST_LOAD;
        end
        ST_OUT: begin
          if (hash_idx_q == digest_len(nn_i) - 6'd1) begin
            hash_idx_q <= 6'd0;
            state      <= ST_IDLE;
          end else begin
            hash_idx_q <= hash_idx_q + 6'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hash_ctrl.md
HASH_CTRL -- requirements
Module: hash_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 nreset  in  1  reset, synchronous, active-low.
REQ-003 data_v_i  in  1  message byte valid from byte-stream front end.
REQ-004 data_i  in  8  message byte.
REQ-005 data_idx_i  in  6  byte position within current 64-byte block.
REQ-006 block_first_i  in  1  current block is first of message.
REQ-007 block_last_i  in  1  current block is last of message.
REQ-008 kk_i / nn_i  in  6 / 6  key length, digest length in bytes; ll_i  in  64  message length in bytes.
REQ-009 ready_v_o  out  1  controller accepts message bytes.
REQ-010 msg_we_o, msg_idx_o[5:0], msg_o[7:0]  out  write port to message buffer.
REQ-011 h_init_o  out  1  pulse: load h with IV xor {8'h01, 8'h01, 2'b0, kk_i, 2'b0, nn_i}.
REQ-012 cmp_start_o  out  1  pulse: load v from h, IV, t_o, last_o.
REQ-013 round_o[3:0], diag_o  out  current round 0..9, column(0)/diagonal(1) half.
REQ-014 t_o[63:0], last_o  out  byte offset counter, final-block flag f0.
REQ-015 fin_o  out  1  pulse: h <= h xor v_low xor v_high.
REQ-016 hash_v_o, hash_idx_o[5:0]  out  digest byte read strobe and index.
REQ-017 err_o  out  1  sticky: byte dropped while busy.

Function
REQ-018 FSM states IDLE, LOAD, COMP, FIN, OUT; one-hot or binary, implementer's choice.
REQ-019 ready_v_o SHALL be 1 exactly in IDLE and LOAD.
REQ-020 IDLE: data_v_i with data_idx_i==0 and block_first_i -> h_init_o pulse same cycle, t cleared, enter LOAD; other bytes dropped.
REQ-021 IDLE/LOAD accepted byte -> msg_we_o=1, msg_idx_o=data_idx_i, msg_o=data_i, combinational same cycle.
REQ-022 LOAD: byte with data_idx_i==63 -> latch block_last_i into last_q, next cycle COMP.
REQ-023 COMP entry cycle: cmp_start_o=1, round_o=0, diag_o=0; COMP lasts exactly 20 cycles stepping (r,d) = (0,0),(0,1),(1,0)..(9,1).
REQ-024 t_o during COMP: non-last block -> previous t + 64; last block -> ll_i + (kk_i!=0 ? 64 : 0); 64-bit wrap-around, no saturation.
REQ-025 last_o = last_q during COMP and FIN, else 0.
REQ-026 FIN: one cycle, fin_o=1; next state OUT if last_q else LOAD.
REQ-027 OUT: hash_v_o=1 for N cycles, hash_idx_o 0..N-1; N = nn_i if 1<=nn_i<=32 else 32; then IDLE.
REQ-028 data_v_i in COMP, FIN or OUT -> byte dropped, msg_we_o=0, err_o set until reset.
REQ-029 data_v_i with block_first_i in LOAD at idx 0 -> restart: h_init_o pulse, t cleared, stay LOAD.
REQ-030 kk_i, nn_i, ll_i sampled combinationally; host holds them stable from first byte to end of OUT.
REQ-031 Total block latency: idx-63 byte at cycle N -> cmp_start_o at N+1, fin_o at N+21, next ready_v_o at N+22.

Reset
REQ-032 nreset low at clk edge -> IDLE, t=0, last_q=0, round/diag=0, hash_idx=0, err_o=0, regardless of state.
REQ-033 Reset values: ready_v_o=1, all pulses and strobes 0, t_o=0, last_o=0.

Structure
REQ-034 Shared package: FSM state encoding, ROUNDS=10, BLOCK_BYTES=64, MAX_NN=32, param-word constant 8'h01.
REQ-035 One sub-module hash_round_cnt: 4-bit round plus diag counter with start, done at (9,1).

Verification
REQ-036 kk=0,nn=32,ll=3, one block -> h_init_o once, cmp_start_o at N+1, t_o=3, last_o=1, 32 hash_v_o cycles idx 0..31, back IDLE.
REQ-037 kk=0,ll=128, two blocks -> first COMP t_o=64,last_o=0; second t_o=128,last_o=1; ready_v_o low 21 cycles per block.
REQ-038 kk=16,nn=20,ll=10 -> key block t_o=64, data block t_o=74, exactly 20 hash_v_o cycles.
REQ-039 Byte sent during COMP -> msg_we_o=0, err_o=1 sticky, hash result sequencing unchanged.
REQ-040 nreset pulsed mid-COMP at round 5 -> IDLE next cycle, ready_v_o=1, t_o=0, no fin_o.
REQ-041 nn=0 and nn=40 -> 32 hash_v_o cycles each.
